// File: rtl/jk_seq_pkg.sv
// Shared opcodes and sequencer state encoding for the JK bank sequencer.
package jk_seq_pkg;

  localparam logic [2:0] OP_HOLD    = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_CLEAR   = 3'd2;
  localparam logic [2:0] OP_SET     = 3'd3;
  localparam logic [2:0] OP_CNT_UP  = 3'd4;
  localparam logic [2:0] OP_CNT_DN  = 3'd5;
  localparam logic [2:0] OP_TOGGLE  = 3'd6;
  localparam logic [2:0] OP_SHIFT_L = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Opcodes 4-7 repeat for cmd_len steps; 0-3 always take one step.
  function automatic logic is_multi(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Command handshake and bank observation bundle for jk_bank_sequencer.
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len,
    input  cmd_ready, q, j_out, k_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len,
    output cmd_ready, q, j_out, k_out, busy, done
  );
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high clear.
module jk_cell (
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    case ({j, k})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Sequences a bank of JK cells: accepts one command in IDLE, drives J/K for
// one or cmd_len steps in RUN, then pulses done for one cycle in DONE.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic          clk,
  input  logic          clr,
  jk_bank_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] q_bank;
  logic [WIDTH-1:0] j_drv;
  logic [WIDTH-1:0] k_drv;
  logic             up_all;
  logic             dn_all;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          if (!is_multi(bus.cmd_op)) begin
            state_d = S_RUN;
            cnt_d   = LEN_W'(1);
          end else if (bus.cmd_len == '0) begin
            // Zero-length repeat completes without touching the bank.
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_RUN;
            cnt_d   = bus.cmd_len;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= OP_HOLD;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Counter drive: a bit toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    j_drv  = '0;
    k_drv  = '0;
    up_all = 1'b1;
    dn_all = 1'b1;
    if (state_q == S_RUN) begin
      case (op_q)
        OP_LOAD: begin
          j_drv = data_q;
          k_drv = ~data_q;
        end
        OP_CLEAR: k_drv = '1;
        OP_SET:   j_drv = '1;
        OP_CNT_UP: begin
          for (int i = 0; i < WIDTH; i++) begin
            j_drv[i] = up_all;
            k_drv[i] = up_all;
            up_all   = up_all & q_bank[i];
          end
        end
        OP_CNT_DN: begin
          for (int i = 0; i < WIDTH; i++) begin
            j_drv[i] = dn_all;
            k_drv[i] = dn_all;
            dn_all   = dn_all & ~q_bank[i];
          end
        end
        OP_TOGGLE: begin
          j_drv = data_q;
          k_drv = data_q;
        end
        OP_SHIFT_L: begin
          j_drv = {q_bank[WIDTH-2:0], data_q[0]};
          k_drv = ~{q_bank[WIDTH-2:0], data_q[0]};
        end
        default: begin
          j_drv = '0;
          k_drv = '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .clr (clr),
      .j   (j_drv[g]),
      .k   (k_drv[g]),
      .q   (q_bank[g])
    );
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.q         = q_bank;
  assign bus.j_out     = j_drv;
  assign bus.k_out     = k_drv;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed plus random command checks of jk_bank_sequencer against an arithmetic bank model.
module tb_jk_bank_sequencer;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;
  localparam logic [WIDTH-1:0] ALL1 = '1;

  logic clk = 1'b0;
  logic clr;
  int   tests = 0;
  int   fails = 0;
  logic [WIDTH-1:0] mq;

  jk_bank_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  jk_bank_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs outside the accept edge must have no effect.
  task automatic noise();
    bus.cmd_valid = 1'($urandom);
    bus.cmd_op    = 3'($urandom);
    bus.cmd_data  = WIDTH'($urandom);
    bus.cmd_len   = LEN_W'($urandom);
  endtask

  function automatic logic [WIDTH-1:0] next_q(input logic [2:0] op, input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] d);
    case (op)
      3'd0: return q;
      3'd1: return d;
      3'd2: return '0;
      3'd3: return ALL1;
      3'd4: return WIDTH'((int'(q) + 1) % (1 << WIDTH));
      3'd5: return WIDTH'((int'(q) + (1 << WIDTH) - 1) % (1 << WIDTH));
      3'd6: return q ^ d;
      default: return WIDTH'((int'(q) * 2 + int'(d[0])) % (1 << WIDTH));
    endcase
  endfunction

  task automatic exp_jk(input logic [2:0] op, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] d,
                        output logic [WIDTH-1:0] j, output logic [WIDTH-1:0] k);
    logic [WIDTH-1:0] nx;
    nx = next_q(op, q, d);
    case (op)
      3'd0: begin j = '0;     k = '0;     end
      3'd1: begin j = d;      k = ~d;     end
      3'd2: begin j = '0;     k = ALL1;   end
      3'd3: begin j = ALL1;   k = '0;     end
      3'd6: begin j = d;      k = d;      end
      3'd7: begin j = nx;     k = ~nx;    end
      default: begin j = q ^ nx; k = q ^ nx; end
    endcase
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] d, input int len);
    int n;
    logic [WIDTH-1:0] ej, ek;
    n = (op < 3'd4) ? 1 : len;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_len   = LEN_W'(len);
    @(posedge clk); #1;
    noise();
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      exp_jk(op, mq, d, ej, ek);
      chk("run_q", 32'(bus.q), 32'(mq));
      chk("run_j", 32'(bus.j_out), 32'(ej));
      chk("run_k", 32'(bus.k_out), 32'(ek));
      chk("run_ready", 32'(bus.cmd_ready), 32'd0);
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_done", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      mq = next_q(op, mq, d);
      noise();
    end
    @(negedge clk);
    chk("done_q", 32'(bus.q), 32'(mq));
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd1);
    chk("done_ready", 32'(bus.cmd_ready), 32'd0);
    chk("done_jk", 32'({bus.j_out, bus.k_out}), 32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("idle_q", 32'(bus.q), 32'(mq));
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    clr           = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd3;
    bus.cmd_data  = ALL1;
    bus.cmd_len   = '0;
    mq            = '0;

    @(posedge clk);
    @(negedge clk);
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    clr           = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_rel_q", 32'(bus.q), 32'd0);
    chk("rst_rel_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rel_busy", 32'(bus.busy), 32'd0);
    chk("rst_rel_jk", 32'({bus.j_out, bus.k_out}), 32'd0);
    @(negedge clk);
    chk("rst_no_cmd", 32'(bus.q), 32'd0);

    run_cmd(3'd1, 4'b1011, 0);
    chk("load_1011", 32'(bus.q), 32'hB);
    run_cmd(3'd2, 4'b0110, 0);
    chk("clear", 32'(bus.q), 32'h0);
    run_cmd(3'd1, 4'b1110, 0);
    run_cmd(3'd4, 4'b0000, 3);
    chk("cnt_up_wrap", 32'(bus.q), 32'h1);
    run_cmd(3'd5, 4'b0000, 2);
    chk("cnt_dn_wrap", 32'(bus.q), 32'hF);
    run_cmd(3'd7, 4'b1110, 2);
    chk("shift_l", 32'(bus.q), 32'hC);
    run_cmd(3'd4, 4'b0000, 0);
    chk("len0_hold", 32'(bus.q), 32'hC);

    // Abort a TOGGLE after two of its five steps.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd6;
    bus.cmd_data  = 4'b0101;
    bus.cmd_len   = LEN_W'(5);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("abort_j", 32'(bus.j_out), 32'h5);
      chk("abort_q", 32'(bus.q), 32'(mq));
      @(posedge clk); #1;
      mq = mq ^ 4'b0101;
    end
    clr = 1'b1;
    @(negedge clk);
    chk("abort_pre_q", 32'(bus.q), 32'(mq));
    chk("abort_pre_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    mq  = '0;
    @(negedge clk);
    chk("abort_q0", 32'(bus.q), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    chk("abort_no_done", 32'(bus.done), 32'd0);

    for (int r = 0; r < 25; r++) begin
      run_cmd(3'($urandom_range(0, 7)), WIDTH'($urandom), $urandom_range(0, 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
Controller that sequences a bank of WIDTH JK flip-flops. It accepts commands over a valid/ready handshake and generates per-bit J/K drive for one or more cycles to load, clear, set, count, toggle or shift the bank. The bank is held inside the block as jk_cell instances. It is the control layer over the lab's JK flip-flop datapath.

Parameters:
WIDTH, 4, number of JK cells in the bank
LEN_W, 8, width of the step-count field cmd_len

Ports:
clk  input  1  rising-edge clock
clr  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command; high only in IDLE
cmd_op  input  3  opcode: 0 HOLD, 1 LOAD, 2 CLEAR, 3 SET, 4 CNT_UP, 5 CNT_DN, 6 TOGGLE, 7 SHIFT_L
cmd_data  input  WIDTH  LOAD value, TOGGLE mask, or SHIFT_L serial bit (bit 0)
cmd_len  input  LEN_W  step count for ops 4-7; ignored for ops 0-3
q  output  WIDTH  bank state
j_out  output  WIDTH  J drive currently applied to the cells
k_out  output  WIDTH  K drive currently applied to the cells
busy  output  1  high in RUN or DONE
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Clock and reset: single clock clk. Reset clr is synchronous and active-high.
- Reset values: q=0, state=IDLE, done=0, busy=0, j_out=k_out=0, internal count=0.
- A command offered in the same cycle as clr is discarded.
- clr during RUN or DONE aborts the command. No done pulse is produced.
- Handshake: a command is accepted at a rising edge when cmd_valid && cmd_ready.
  - cmd_op, cmd_data and cmd_len are latched at acceptance.
  - Inputs are ignored at all other times.
- State machine:
  - IDLE -> RUN on accept.
  - RUN -> DONE on the edge that applies the final step.
  - DONE -> IDLE after exactly one cycle, with done=1 during that cycle.
  - Exception: a multi-step op with cmd_len=0 goes IDLE -> DONE directly. No q change.
- Step count: ops 0-3 are one step. Ops 4-7 take cmd_len steps, with cmd_len up to 2^LEN_W-1.
- Latency: for a command accepted at edge E0 with n>=1 steps, q updates at edges E1..En and done is high in the cycle after En. Back-to-back commands are therefore separated by at least n+2 cycles.
- J/K drive in RUN (combinational from q and the latched command; zero outside RUN):
  - HOLD: J=0, K=0.
  - LOAD: J=d, K=~d.
  - CLEAR: J=0, K=all-ones.
  - SET: J=all-ones, K=0.
  - CNT_UP: J[i]=K[i]=AND(q[i-1:0]), with bit 0 always toggling. Wraps from all-ones to 0.
  - CNT_DN: J[i]=K[i]=AND(~q[i-1:0]), with bit 0 always toggling. Wraps from 0 to all-ones.
  - TOGGLE: J=K=mask.
  - SHIFT_L: J[i]=q[i-1], K[i]=~q[i-1]. Bit 0 takes the latched serial bit. The MSB is discarded.
- Cell rule (jk_cell), per edge:
  - clr -> 0
  - 00 hold
  - 01 -> 0
  - 10 -> 1
  - 11 -> toggle
- Counting arithmetic is modulo 2^WIDTH.
- cmd_ready=0 throughout RUN and DONE. A cmd_valid held high is accepted on the first edge after the return to IDLE.

Decomposition:
- Shared package jk_seq_pkg:
  - opcode localparams OP_HOLD..OP_SHIFT_L
  - state encoding S_IDLE=0, S_RUN=1, S_DONE=2
- Sub-module jk_cell: a single JK flip-flop with synchronous clr. Ports clk, clr, j, k, q. Instantiated WIDTH times via generate.
- The sequencer FSM, step counter and J/K drive logic live in jk_bank_sequencer.

Test Plan:
- Reset: assert clr for 2 cycles with cmd_valid=1. Require q=0000, cmd_ready=1 after release, and no command executed.
- LOAD then CLEAR:
  - LOAD data=1011 -> q=1011 one edge after accept, done pulse the next cycle.
  - CLEAR -> q=0000.
- CNT_UP wrap: LOAD 1110, then CNT_UP len=3 -> q goes 1111, 0000, 0001 on consecutive edges. done high for exactly 1 cycle. cmd_ready low for 4 cycles.
- CNT_DN and SHIFT_L:
  - From 0001, CNT_DN len=2 -> 0000, 1111.
  - Then SHIFT_L len=2 with data[0]=0 -> 1110, 1100.
- len=0 and abort:
  - CNT_UP len=0 -> q unchanged, done in the cycle after accept.
  - TOGGLE mask=0101 len=5, then clr after 2 steps -> q=0000, no done pulse, IDLE next cycle.
